// File: rtl/exe_result_arbiter.sv
// Result arbiter for the EXE functional units. Fixed priority (lowest index
// wins) with an age counter per unit that forces a grant to a starved unit.
// Results leave through one registered stage with valid/ready backpressure.
module exe_result_arbiter #(
    parameter int N_UNITS  = 10,
    parameter int W        = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic [N_UNITS-1:0]   unit_valid_i,
    input  logic [N_UNITS*W-1:0] unit_data_i,
    input  logic [N_UNITS*5-1:0] unit_rd_i,
    output logic [N_UNITS-1:0]   unit_ready_o,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [W-1:0]         out_data_o,
    output logic [4:0]           out_rd_o,
    output logic [3:0]           out_unit_o
);

    localparam int AW = $clog2(MAX_WAIT + 1);

    logic [AW-1:0]      r_age [N_UNITS];
    logic               r_valid;
    logic [W-1:0]       r_data;
    logic [4:0]         r_rd;
    logic [3:0]         r_unit;

    logic [N_UNITS-1:0] w_aged;
    logic [N_UNITS-1:0] w_sel;
    logic [N_UNITS-1:0] w_grant;
    logic [N_UNITS-1:0] w_ready;
    logic [3:0]         w_gidx;
    logic [W-1:0]       w_data;
    logic [4:0]         w_rd;
    logic               w_load;
    logic               w_acc;

    // Grant: lowest-index aged requester if any, else lowest-index requester.
    always_comb begin
        w_gidx  = '0;
        w_grant = '0;
        w_data  = '0;
        w_rd    = '0;
        for (int i = 0; i < N_UNITS; i++)
            w_aged[i] = unit_valid_i[i] && (r_age[i] == AW'(MAX_WAIT));
        w_sel = (|w_aged) ? w_aged : unit_valid_i;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_gidx  = 4'(i);
                w_grant = N_UNITS'(1) << i;
            end
        end
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_gidx == 4'(i)) begin
                w_data = unit_data_i[i*W +: W];
                w_rd   = unit_rd_i[i*5 +: 5];
            end
        end
    end

    assign w_load       = ~r_valid | out_ready_i;
    assign w_ready      = w_grant & {N_UNITS{w_load & ~flush_i & reset_n}};
    assign w_acc        = |w_ready;
    assign unit_ready_o = w_ready;

    // Age counters: count waiting cycles, clear on accept/idle/flush, saturate.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (!reset_n || flush_i || w_ready[i] || !unit_valid_i[i])
                r_age[i] <= '0;
            else if (r_age[i] != AW'(MAX_WAIT))
                r_age[i] <= r_age[i] + AW'(1);
        end
    end

    // Output stage: flush drops the result, accept loads, downstream take drains.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_rd    <= '0;
            r_unit  <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_rd    <= w_rd;
            r_unit  <= w_gidx;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_rd_o    = r_rd;
    assign out_unit_o  = r_unit;

endmodule

// File: tb/tb_exe_result_arbiter.sv
// Directed bench for exe_result_arbiter: reset, priority, drain, starvation,
// backpressure and flush, with hand-computed expectations.
module tb_exe_result_arbiter;

    localparam int N = 10;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           flush_i;
    logic [N-1:0]   unit_valid_i;
    logic [N*W-1:0] unit_data_i;
    logic [N*5-1:0] unit_rd_i;
    logic [N-1:0]   unit_ready_o;
    logic           out_ready_i;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
    logic [4:0]     out_rd_o;
    logic [3:0]     out_unit_o;

    int n_chk = 0;
    int n_err = 0;

    exe_result_arbiter #(.N_UNITS(N), .W(W), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .unit_valid_i (unit_valid_i),
        .unit_data_i  (unit_data_i),
        .unit_rd_i    (unit_rd_i),
        .unit_ready_o (unit_ready_o),
        .out_ready_i  (out_ready_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_rd_o     (out_rd_o),
        .out_unit_o   (out_unit_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dat(input int i);
        return 32'hA000_0000 + W'(i);
    endfunction

    initial begin
        reset_n      = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b1;
        unit_valid_i = '1;
        for (int i = 0; i < N; i++) begin
            unit_data_i[i*W +: W] = dat(i);
            unit_rd_i[i*5 +: 5]   = 5'(i + 1);
        end

        // Reset with every unit requesting
        step();
        step();
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_ready", 64'(unit_ready_o), 64'd0);
        chk("rst_unit",  64'(out_unit_o), 64'd0);
        chk("rst_data",  64'(out_data_o), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_release_grant", 64'(unit_ready_o), 64'h1);
        unit_valid_i = '0;
        step();

        // Priority: units 2 and 6
        unit_valid_i = N'(1) << 2 | N'(1) << 6;
        #1;
        chk("prio_c0_ready", 64'(unit_ready_o), 64'(N'(1) << 2));
        step();
        unit_valid_i = N'(1) << 6;
        #1;
        chk("prio_c1_unit",  64'(out_unit_o), 64'd2);
        chk("prio_c1_data",  64'(out_data_o), 64'(dat(2)));
        chk("prio_c1_rd",    64'(out_rd_o), 64'd3);
        chk("prio_c1_ready", 64'(unit_ready_o), 64'(N'(1) << 6));
        step();
        unit_valid_i = '0;
        #1;
        chk("prio_c2_unit",  64'(out_unit_o), 64'd6);
        chk("prio_c2_valid", 64'(out_valid_o), 64'd1);
        chk("prio_c2_rd",    64'(out_rd_o), 64'd7);
        // Drain: nothing else requested, valid lasts one cycle
        step();
        chk("drain_valid", 64'(out_valid_o), 64'd0);

        // Starvation: unit 0 always valid, unit 6 force-granted at age 8
        unit_valid_i = N'(1) | N'(1) << 6;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("starve_c%0d_ready", c), 64'(unit_ready_o),
                (c == 8) ? 64'(N'(1) << 6) : 64'h1);
            step();
            if (c == 8) unit_valid_i = N'(1);
            chk($sformatf("starve_c%0d_unit", c), 64'(out_unit_o),
                (c == 8) ? 64'd6 : 64'd0);
        end
        unit_valid_i = '0;
        step();
        step();

        // Backpressure: load unit 4, then stall with unit 1 waiting
        unit_valid_i = N'(1) << 4;
        out_ready_i  = 1'b1;
        #1;
        step();
        unit_valid_i = N'(1) << 1;
        out_ready_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_c%0d_ready", c), 64'(unit_ready_o), 64'd0);
            chk($sformatf("bp_c%0d_data", c),  64'(out_data_o), 64'(dat(4)));
            chk($sformatf("bp_c%0d_valid", c), 64'(out_valid_o), 64'd1);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 64'(unit_ready_o), 64'(N'(1) << 1));
        step();
        unit_valid_i = '0;
        #1;
        chk("bp_after_unit", 64'(out_unit_o), 64'd1);
        chk("bp_after_data", 64'(out_data_o), 64'(dat(1)));

        // Flush while output valid and unit 3 requesting
        unit_valid_i = N'(1) << 3;
        out_ready_i  = 1'b0;
        flush_i      = 1'b1;
        #1;
        chk("flush_ready", 64'(unit_ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1;
        chk("flush_valid",      64'(out_valid_o), 64'd0);
        chk("flush_next_ready", 64'(unit_ready_o), 64'(N'(1) << 3));
        step();
        unit_valid_i = '0;
        #1;
        chk("flush_after_valid", 64'(out_valid_o), 64'd1);
        chk("flush_after_unit",  64'(out_unit_o), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
